// File: rtl/psx_irq_ctrl_if.sv
// CPU-side register bus of the interrupt controller: one-cycle access strobe,
// I_STAT/I_MASK select, and a read-data return strobed one cycle later.
interface psx_irq_ctrl_if;
    logic        i_cs;
    logic        i_we;
    logic        i_addr;
    logic [31:0] i_wdata;
    logic [31:0] o_rdata;
    logic        o_rvalid;

    modport master (
        output i_cs, i_we, i_addr, i_wdata,
        input  o_rdata, o_rvalid
    );

    modport slave (
        input  i_cs, i_we, i_addr, i_wdata,
        output o_rdata, o_rvalid
    );
endinterface

// File: rtl/psx_irq_ctrl.sv
// PSX interrupt controller: edge-latched I_STAT, I_MASK, CPU IRQ line and
// per-source acknowledge pulses. One bit cell per source, replicated by generate.

// Per-source slice: edge detector, sticky status bit, mask bit, ack pulse.
module psx_irq_bit (
    input  logic i_clk,
    input  logic i_nRst,
    input  logic i_src,
    input  logic i_statWr,
    input  logic i_ackBit,
    input  logic i_maskWr,
    input  logic i_maskBit,
    output logic o_stat,
    output logic o_mask,
    output logic o_ack
);
    logic prev;
    logic rise;
    logic keep;

    assign rise = i_src & ~prev;
    // Writing 0 clears, writing 1 (or no write) keeps; a fresh edge always wins.
    assign keep = ~i_statWr | i_ackBit;

    always_ff @(posedge i_clk) begin
        if (!i_nRst) begin
            prev   <= i_src;
            o_stat <= 1'b0;
            o_mask <= 1'b0;
            o_ack  <= 1'b0;
        end else begin
            prev   <= i_src;
            o_stat <= (o_stat & keep) | rise;
            if (i_maskWr)
                o_mask <= i_maskBit;
            o_ack  <= o_stat & ~keep & ~rise;
        end
    end
endmodule

module psx_irq_ctrl #(
    parameter int NUM_SRC = 11
) (
    input  logic               i_clk,
    input  logic               i_nRst,
    input  logic [NUM_SRC-1:0] i_src,
    psx_irq_ctrl_if.slave      bus,
    output logic [NUM_SRC-1:0] o_srcAck,
    output logic               o_irq
);
    logic               stat_wr;
    logic               mask_wr;
    logic               rd;
    logic [NUM_SRC-1:0] stat;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] ack;
    logic [NUM_SRC-1:0] rd_sel;
    logic               unused_wdata;

    assign stat_wr = bus.i_cs &  bus.i_we & ~bus.i_addr;
    assign mask_wr = bus.i_cs &  bus.i_we &  bus.i_addr;
    assign rd      = bus.i_cs & ~bus.i_we;

    // Upper write-data bits have no backing storage.
    assign unused_wdata = &{1'b0, bus.i_wdata[31:NUM_SRC]};

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        psx_irq_bit u_bit (
            .i_clk     (i_clk),
            .i_nRst    (i_nRst),
            .i_src     (i_src[g]),
            .i_statWr  (stat_wr),
            .i_ackBit  (bus.i_wdata[g]),
            .i_maskWr  (mask_wr),
            .i_maskBit (bus.i_wdata[g]),
            .o_stat    (stat[g]),
            .o_mask    (mask[g]),
            .o_ack     (ack[g])
        );
    end

    assign o_srcAck = ack;
    assign o_irq    = |(stat & mask);
    assign rd_sel   = bus.i_addr ? mask : stat;

    // Read returns pre-update register contents; reset drops any pending strobe.
    always_ff @(posedge i_clk) begin
        if (!i_nRst) begin
            bus.o_rdata  <= 32'd0;
            bus.o_rvalid <= 1'b0;
        end else begin
            bus.o_rvalid <= rd;
            if (rd)
                bus.o_rdata <= {{(32-NUM_SRC){1'b0}}, rd_sel};
        end
    end
endmodule

// File: tb/tb_psx_irq_ctrl.sv
// Directed bench for psx_irq_ctrl: inputs change on negedge, outputs sampled on negedge.
module tb_psx_irq_ctrl;
    localparam int NUM_SRC = 11;

    logic               clk = 1'b0;
    logic               nRst;
    logic [NUM_SRC-1:0] src;
    logic [NUM_SRC-1:0] srcAck;
    logic               irq;
    int                 n_chk = 0;
    int                 n_err = 0;

    psx_irq_ctrl_if bus ();

    psx_irq_ctrl #(.NUM_SRC(NUM_SRC)) dut (
        .i_clk    (clk),
        .i_nRst   (nRst),
        .i_src    (src),
        .bus      (bus),
        .o_srcAck (srcAck),
        .o_irq    (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic bus_wr(input logic addr, input logic [31:0] data);
        bus.i_cs = 1'b1; bus.i_we = 1'b1; bus.i_addr = addr; bus.i_wdata = data;
        cyc();
        bus.i_cs = 1'b0; bus.i_we = 1'b0; bus.i_wdata = 32'hDEAD_BEEF;
    endtask

    task automatic bus_rd(input string tag, input logic addr, input logic [31:0] exp);
        bus.i_cs = 1'b1; bus.i_we = 1'b0; bus.i_addr = addr;
        cyc();
        bus.i_cs = 1'b0;
        chk({tag, "_rvalid"}, {31'd0, bus.o_rvalid}, 32'd1);
        chk(tag, bus.o_rdata, exp);
    endtask

    initial begin
        nRst = 1'b0; src = 11'h002;
        bus.i_cs = 1'b0; bus.i_we = 1'b0; bus.i_addr = 1'b0; bus.i_wdata = 32'd0;
        repeat (3) cyc();
        chk("rst_rvalid", {31'd0, bus.o_rvalid}, 32'd0);
        chk("rst_rdata",  bus.o_rdata, 32'd0);
        chk("rst_ack",    {21'd0, srcAck}, 32'd0);
        chk("rst_irq",    {31'd0, irq}, 32'd0);

        // 1: line held high through reset release raises no event
        nRst = 1'b1;
        bus_wr(1'b1, 32'h0000_0002);
        for (int i = 0; i < 10; i++) chk("t1_hold_irq", {31'd0, irq}, 32'd0);
        repeat (10) cyc();
        bus_rd("t1_stat_hold", 1'b0, 32'h000);
        src = 11'h000; cyc();
        src = 11'h002; cyc();
        bus_rd("t1_stat_rise", 1'b0, 32'h002);
        bus_wr(1'b0, 32'h0000_07FD);
        chk("t1_ack", {21'd0, srcAck}, 32'h002);
        src = 11'h000; cyc();

        // 2: single-cycle pulse, ack via STAT write
        src = 11'h002; cyc();
        src = 11'h000;
        chk("t2_irq_rise", {31'd0, irq}, 32'd1);
        bus_rd("t2_stat", 1'b0, 32'h002);
        bus_wr(1'b0, 32'h0000_07FD);
        chk("t2_ack",      {21'd0, srcAck}, 32'h002);
        chk("t2_irq_fall", {31'd0, irq}, 32'd0);
        cyc();
        chk("t2_ack_pulse", {21'd0, srcAck}, 32'h000);
        chk("t2_rvalid_pulse", {31'd0, bus.o_rvalid}, 32'd0);
        bus_rd("t2_stat_clr", 1'b0, 32'h000);

        // 3: rise beats same-cycle ack
        src = 11'h001; cyc();
        src = 11'h000; cyc();
        src = 11'h001;
        bus_wr(1'b0, 32'h0000_0000);
        chk("t3_ack_none", {21'd0, srcAck}, 32'h000);
        src = 11'h000;
        bus_rd("t3_stat", 1'b0, 32'h001);
        bus_wr(1'b0, 32'h0000_07FE);
        chk("t3_ack", {21'd0, srcAck}, 32'h001);

        // 4: masked bits still latch; unmasking raises irq next cycle
        bus_wr(1'b1, 32'h0000_0000);
        src = 11'h009; cyc();
        src = 11'h000;
        chk("t4_irq_masked", {31'd0, irq}, 32'd0);
        bus_rd("t4_stat", 1'b0, 32'h009);
        bus_wr(1'b1, 32'h0000_0008);
        chk("t4_irq_unmask", {31'd0, irq}, 32'd1);
        bus_wr(1'b0, 32'h0000_0000);
        chk("t4_ack", {21'd0, srcAck}, 32'h009);
        chk("t4_irq_clr", {31'd0, irq}, 32'd0);

        // 5: read returns pre-update value; rdata holds after the strobe
        src = 11'h004;
        bus_rd("t5_rd_old", 1'b0, 32'h000);
        src = 11'h000;
        cyc();
        chk("t5_rvalid_drop", {31'd0, bus.o_rvalid}, 32'd0);
        chk("t5_rdata_hold",  bus.o_rdata, 32'h000);
        bus_rd("t5_rd_new", 1'b0, 32'h004);
        bus_wr(1'b0, 32'h0000_0000);

        // 6: upper wdata bits ignored; writing ones never sets STAT
        bus_wr(1'b1, 32'hFFFF_FFFF);
        bus_rd("t6_mask", 1'b1, 32'h0000_07FF);
        bus_wr(1'b0, 32'hFFFF_FFFF);
        chk("t6_ack_none", {21'd0, srcAck}, 32'h000);
        bus_rd("t6_stat_zero", 1'b0, 32'h000);
        src = 11'h020; cyc();
        src = 11'h000;
        bus_wr(1'b0, 32'hFFFF_FFFF);
        bus_rd("t6_stat_kept", 1'b0, 32'h020);
        chk("t6_irq", {31'd0, irq}, 32'd1);

        // back-to-back reads, one-cycle latency each
        bus.i_cs = 1'b1; bus.i_we = 1'b0; bus.i_addr = 1'b0; cyc();
        bus.i_addr = 1'b1;
        chk("bb_rd0", bus.o_rdata, 32'h020);
        cyc();
        bus.i_cs = 1'b0;
        chk("bb_rvalid", {31'd0, bus.o_rvalid}, 32'd1);
        chk("bb_rd1", bus.o_rdata, 32'h7FF);

        // reset mid-operation drops the pending read strobe
        bus.i_cs = 1'b1; bus.i_we = 1'b0; bus.i_addr = 1'b0; nRst = 1'b0;
        cyc();
        bus.i_cs = 1'b0;
        chk("mid_rst_rvalid", {31'd0, bus.o_rvalid}, 32'd0);
        chk("mid_rst_irq",    {31'd0, irq}, 32'd0);
        nRst = 1'b1; cyc();
        bus_rd("mid_rst_mask", 1'b1, 32'h000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
